// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises, debounces and validates three raw coin sensors.
// Emits one registered RON pulse per accepted coin, and a REJECT pulse for jams or for coins inserted while disabled.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SENS1,
    input  logic             SENS5,
    input  logic             SENS10,
    input  logic             ENABLE,
    output logic             RON1,
    output logic             RON5,
    output logic             RON10,
    output logic             REJECT,
    output logic             JAM,
    output logic [CNT_W-1:0] COIN_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE,
        ST_GAP,
        ST_JAM
    } state_e;

    localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Sensor vectors are ordered {10, 5, 1} throughout.
    logic [2:0]       sens_raw;
    logic [2:0]       meta_q, sync_q;
    logic [2:0]       s;
    logic             any_s, one_s;

    state_e           state_q, state_d;
    logic [2:0]       coin_q, coin_d;
    logic [7:0]       deb_cnt_q, deb_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [2:0]       ron_q, ron_d;
    logic             reject_q, reject_d;
    logic             jam_q, jam_d;
    logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;

    assign sens_raw = {SENS10, SENS5, SENS1};
    assign s        = sync_q;
    assign any_s    = |s;
    assign one_s    = any_s && ((s & (s - 3'd1)) == 3'd0);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
        state_d    = state_q;
        coin_d     = coin_q;
        deb_cnt_d  = deb_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ron_d      = 3'b000;
        reject_d   = 1'b0;
        coin_cnt_d = coin_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_s && !one_s) begin
                    state_d  = ST_JAM;
                    reject_d = 1'b1;
                end else if (one_s) begin
                    if (ENABLE) begin
                        coin_d    = s;
                        deb_cnt_d = 8'd1;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = ST_RELEASE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (|(s & ~coin_q)) begin
                    state_d  = ST_JAM;
                    reject_d = 1'b1;
                end else if (!(|(s & coin_q))) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    // Pulse and count are registered on the edge that enters EMIT.
                    state_d = ST_EMIT;
                    ron_d   = coin_q;
                    if (coin_cnt_q != CNT_MAX) begin
                        coin_cnt_d = coin_cnt_q + CNT_W'(1);
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            ST_EMIT: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE, ST_JAM: begin
                if (!any_s) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = 8'd0;
                end
            end
            ST_GAP: begin
                if (any_s) begin
                    gap_cnt_d = 8'd0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        jam_d = (state_d == ST_JAM);
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values, whatever the statement order.
        if (RESET) begin
            meta_q     <= 3'b000;
            sync_q     <= 3'b000;
            state_q    <= ST_IDLE;
            coin_q     <= 3'b000;
            deb_cnt_q  <= 8'd0;
            gap_cnt_q  <= 8'd0;
            ron_q      <= 3'b000;
            reject_q   <= 1'b0;
            jam_q      <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            meta_q     <= sens_raw;
            sync_q     <= meta_q;
            state_q    <= state_d;
            coin_q     <= coin_d;
            deb_cnt_q  <= deb_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ron_q      <= ron_d;
            reject_q   <= reject_d;
            jam_q      <= jam_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    assign RON1     = ron_q[0];
    assign RON5     = ron_q[1];
    assign RON10    = ron_q[2];
    assign REJECT   = reject_q;
    assign JAM      = jam_q;
    assign COIN_CNT = coin_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: per-cycle vector table plus hand sequences for counter
// saturation (second instance, CNT_W=2) and reset in the middle of a debounce.
module tb_coin_acceptor;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] sens;   // {SENS10, SENS5, SENS1}
        logic [2:0] ron;    // {RON10, RON5, RON1}
        logic       rej;
        logic       jam;
        logic [7:0] cnt;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SENS1 = 1'b0, SENS5 = 1'b0, SENS10 = 1'b0;
    logic       ENABLE = 1'b1;

    logic       ron1_a, ron5_a, ron10_a, reject_a, jam_a;
    logic [7:0] cnt_a;
    logic       ron1_b, ron5_b, ron10_b, reject_b, jam_b;
    logic [1:0] cnt_b;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    coin_acceptor dut_a (
        .CLK(CLK), .RESET(RESET), .SENS1(SENS1), .SENS5(SENS5), .SENS10(SENS10), .ENABLE(ENABLE),
        .RON1(ron1_a), .RON5(ron5_a), .RON10(ron10_a), .REJECT(reject_a), .JAM(jam_a), .COIN_CNT(cnt_a)
    );

    coin_acceptor #(.CNT_W(2)) dut_b (
        .CLK(CLK), .RESET(RESET), .SENS1(SENS1), .SENS5(SENS5), .SENS10(SENS10), .ENABLE(ENABLE),
        .RON1(ron1_b), .RON5(ron5_b), .RON10(ron10_b), .REJECT(reject_b), .JAM(jam_b), .COIN_CNT(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic rst, input logic en, input logic [2:0] sens,
                       input logic [2:0] ron, input logic rej, input logic jam, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.sens = sens; v.ron = ron; v.rej = rej; v.jam = jam; v.cnt = cnt;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic tick(input logic rst, input logic en, input logic [2:0] sens);
        RESET = rst;
        ENABLE = en;
        {SENS10, SENS5, SENS1} = sens;
        @(posedge CLK);
        #1;
    endtask

    // Raw coin held for 4 cycles then 4 low cycles; counts RON1 pulses on the CNT_W=2 instance.
    task automatic run_coin(output int pulses);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, (i < 4) ? 3'b001 : 3'b000);
            if (ron1_b) pulses++;
        end
    endtask

    initial begin
        int        pulses;
        int        stray;
        int        exp_sat[5];
        logic [12:0] got;
        exp_sat = '{1, 2, 3, 3, 3};

        // Reset, then SENS5 held 8 cycles: RON5 five edges after the first raw-high sample.
        add(1, 1, 1, 3'b000, 3'b000, 0, 0, 8'd0);
        add(2, 0, 1, 3'b000, 3'b000, 0, 0, 8'd0);
        add(5, 0, 1, 3'b010, 3'b000, 0, 0, 8'd0);
        add(1, 0, 1, 3'b010, 3'b010, 0, 0, 8'd1);
        add(2, 0, 1, 3'b010, 3'b000, 0, 0, 8'd1);
        add(5, 0, 1, 3'b000, 3'b000, 0, 0, 8'd1);
        // SENS1 bounce (2 high, 1 low, 2 high) is a glitch; then a clean 6-cycle coin.
        add(2, 0, 1, 3'b001, 3'b000, 0, 0, 8'd1);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd1);
        add(2, 0, 1, 3'b001, 3'b000, 0, 0, 8'd1);
        add(2, 0, 1, 3'b000, 3'b000, 0, 0, 8'd1);
        add(5, 0, 1, 3'b001, 3'b000, 0, 0, 8'd1);
        add(1, 0, 1, 3'b001, 3'b001, 0, 0, 8'd2);
        add(5, 0, 1, 3'b000, 3'b000, 0, 0, 8'd2);
        // SENS10 with dropouts after acceptance: one pulse; a SENS1 coin right after GAP is accepted on time.
        add(5, 0, 1, 3'b100, 3'b000, 0, 0, 8'd2);
        add(1, 0, 1, 3'b100, 3'b100, 0, 0, 8'd3);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd3);
        add(1, 0, 1, 3'b100, 3'b000, 0, 0, 8'd3);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd3);
        add(1, 0, 1, 3'b100, 3'b000, 0, 0, 8'd3);
        add(2, 0, 1, 3'b000, 3'b000, 0, 0, 8'd3);
        add(4, 0, 1, 3'b001, 3'b000, 0, 0, 8'd3);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd3);
        add(1, 0, 1, 3'b000, 3'b001, 0, 0, 8'd4);
        add(4, 0, 1, 3'b000, 3'b000, 0, 0, 8'd4);
        // SENS1+SENS5 together: REJECT once, JAM until both low, then a clean SENS1 coin.
        add(2, 0, 1, 3'b011, 3'b000, 0, 0, 8'd4);
        add(1, 0, 1, 3'b011, 3'b000, 1, 1, 8'd4);
        add(1, 0, 1, 3'b011, 3'b000, 0, 1, 8'd4);
        add(2, 0, 1, 3'b000, 3'b000, 0, 1, 8'd4);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd4);
        add(4, 0, 1, 3'b001, 3'b000, 0, 0, 8'd4);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd4);
        add(1, 0, 1, 3'b000, 3'b001, 0, 0, 8'd5);
        add(4, 0, 1, 3'b000, 3'b000, 0, 0, 8'd5);
        // ENABLE low with SENS5 held 6 cycles: a single REJECT, count unchanged.
        add(2, 0, 0, 3'b010, 3'b000, 0, 0, 8'd5);
        add(1, 0, 0, 3'b010, 3'b000, 1, 0, 8'd5);
        add(3, 0, 0, 3'b010, 3'b000, 0, 0, 8'd5);
        add(5, 0, 0, 3'b000, 3'b000, 0, 0, 8'd5);
        add(1, 0, 1, 3'b000, 3'b000, 0, 0, 8'd5);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].sens);
            got = {ron10_a, ron5_a, ron1_a, reject_a, jam_a, cnt_a};
            check($sformatf("vec%0d {ron10,ron5,ron1,rej,jam,cnt}", i), 32'(got),
                  32'({vecs[i].ron, vecs[i].rej, vecs[i].jam, vecs[i].cnt}));
        end

        // Saturation on the 2-bit counter instance.
        tick(1'b1, 1'b1, 3'b000);
        check("sat_reset_cnt_b", 32'(cnt_b), 32'd0);
        for (int k = 0; k < 5; k++) begin
            run_coin(pulses);
            check($sformatf("sat_coin%0d_pulses", k), pulses, 1);
            check($sformatf("sat_coin%0d_cnt_b", k), 32'(cnt_b), exp_sat[k]);
            check($sformatf("sat_coin%0d_cnt_a", k), 32'(cnt_a), k + 1);
        end

        // Reset while in DEBOUNCE discards the coin.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 3'b001);
        tick(1'b1, 1'b1, 3'b000);
        check("midrst_outputs_a", 32'({ron10_a, ron5_a, ron1_a, reject_a, jam_a, cnt_a}), 32'd0);
        check("midrst_outputs_b", 32'({ron10_b, ron5_b, ron1_b, reject_b, jam_b, cnt_b}), 32'd0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 3'b000);
            if (ron1_a | ron5_a | ron10_a | reject_a | jam_a | ron1_b | ron5_b | ron10_b | reject_b | jam_b)
                stray++;
        end
        check("midrst_no_pulse", stray, 0);
        check("midrst_cnt_a", 32'(cnt_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
